// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, INSTR, DATA} bus_state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;
  localparam logic [3:0] BYTEEN_WORD = 4'b1111;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick between instruction and data requests
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic   req_instr,
  input  logic   req_data,
  input  grant_t last_grant,
  output logic   valid,
  output grant_t grant
);
  assign valid = req_instr | req_data;
  assign grant = (req_instr && req_data) ? (last_grant == GRANT_DATA ? GRANT_INSTR : GRANT_DATA)
               : (req_instr ? GRANT_INSTR : GRANT_DATA);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Avalon-MM bus between instruction fetch and data ports
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_ready,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_ready,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        bus_error
);
  localparam logic [9:0] STALL_MAX = 10'(TIMEOUT_CYCLES - 1);
  bus_state_t  state_q, state_d;
  grant_t      last_grant_q, last_grant_d, gnt;
  logic        gnt_valid;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ird_q, ird_d, drd_q, drd_d, rdata;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d, wr_q, wr_d, irdy_q, irdy_d, drdy_q, drdy_d, err_q, err_d;
  logic [9:0]  stall_q, stall_d;
  rr_arb2 u_arb (
    .req_instr (instr_req),
    .req_data  (data_read | data_write),
    .last_grant(last_grant_q),
    .valid     (gnt_valid),
    .grant     (gnt)
  );
  assign rdata = bus_waitrequest ? 32'h0 : bus_readdata;
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rd_d = rd_q;
    wr_d = wr_q;
    ird_d = ird_q;
    drd_d = drd_q;
    irdy_d = 1'b0;
    drdy_d = 1'b0;
    stall_d = stall_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      if (gnt_valid) begin
        state_d = gnt == GRANT_INSTR ? INSTR : DATA;
        last_grant_d = gnt;
        stall_d = '0;
        addr_d = gnt == GRANT_INSTR ? instr_address : data_address;
        wdata_d = gnt == GRANT_INSTR ? 32'h0 : data_writedata;
        be_d = gnt == GRANT_INSTR ? BYTEEN_WORD : data_byteenable;
        rd_d = gnt == GRANT_INSTR ? 1'b1 : !data_write;
        wr_d = gnt == GRANT_DATA && data_write;
      end
    end else if (!bus_waitrequest || stall_q == STALL_MAX) begin
      state_d = IDLE;
      rd_d = 1'b0;
      wr_d = 1'b0;
      irdy_d = state_q == INSTR;
      drdy_d = state_q == DATA;
      err_d = err_q | bus_waitrequest;
      ird_d = state_q == INSTR ? rdata : ird_q;
      drd_d = (state_q == DATA && rd_q) ? rdata : drd_q;
    end else begin
      stall_d = stall_q + 10'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_grant_q <= GRANT_DATA;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ird_q <= '0;
      drd_q <= '0;
      irdy_q <= 1'b0;
      drdy_q <= 1'b0;
      stall_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ird_q <= ird_d;
      drd_q <= drd_d;
      irdy_q <= irdy_d;
      drdy_q <= drdy_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
  end
  assign bus_address = addr_q;
  assign bus_read = rd_q;
  assign bus_write = wr_q;
  assign bus_writedata = wdata_q;
  assign bus_byteenable = be_q;
  assign instr_readdata = ird_q;
  assign data_readdata = drd_q;
  assign instr_ready = irdy_q;
  assign data_ready = drdy_q;
  assign bus_error = err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req;
  logic [31:0] instr_address, instr_readdata;
  logic        instr_ready;
  logic        data_read, data_write;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic [3:0]  data_byteenable;
  logic        data_ready;
  logic [31:0] bus_address, bus_writedata, bus_readdata;
  logic        bus_read, bus_write, bus_waitrequest, bus_error;
  logic [3:0]  bus_byteenable;
  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_ready(instr_ready),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_ready(data_ready),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
    .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: one outstanding transfer, owner 0=instr 1=data
  logic        m_busy, m_owner, m_last, m_rd, m_wr, m_irdy, m_drdy, m_err;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [3:0]  m_be;
  int          m_waits;
  wire m_dreq = data_read | data_write;
  wire m_pick = (instr_req && m_dreq) ? !m_last : !instr_req;

  always @(posedge clk) begin
    m_irdy <= 1'b0;
    m_drdy <= 1'b0;
    if (!reset_n) begin
      m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0; m_last <= 1'b1;
      m_ird <= '0; m_drd <= '0; m_err <= 1'b0; m_waits <= 0;
    end else if (m_busy) begin
      if (!bus_waitrequest || m_waits + 1 == TO) begin
        m_busy <= 1'b0; m_rd <= 1'b0; m_wr <= 1'b0;
        if (bus_waitrequest) m_err <= 1'b1;
        if (!m_owner) begin
          m_irdy <= 1'b1;
          m_ird <= bus_waitrequest ? 32'h0 : bus_readdata;
        end else begin
          m_drdy <= 1'b1;
          if (m_rd) m_drd <= bus_waitrequest ? 32'h0 : bus_readdata;
        end
      end else m_waits <= m_waits + 1;
    end else if (instr_req || m_dreq) begin
      m_busy <= 1'b1; m_owner <= m_pick; m_last <= m_pick; m_waits <= 0;
      m_addr <= m_pick ? data_address : instr_address;
      m_be <= m_pick ? data_byteenable : 4'hF;
      m_wdata <= data_writedata;
      m_wr <= m_pick && data_write;
      m_rd <= m_pick ? !data_write : 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", 32'(instr_ready), 32'(m_irdy));
    chk("data_ready", 32'(data_ready), 32'(m_drdy));
    chk("bus_read", 32'(bus_read), 32'(m_rd));
    chk("bus_write", 32'(bus_write), 32'(m_wr));
    chk("bus_error", 32'(bus_error), 32'(m_err));
    chk("instr_readdata", instr_readdata, m_ird);
    chk("data_readdata", data_readdata, m_drd);
    if (m_rd || m_wr) begin
      chk("bus_address", bus_address, m_addr);
      chk("bus_byteenable", 32'(bus_byteenable), 32'(m_be));
    end
    if (m_wr) chk("bus_writedata", bus_writedata, m_wdata);
  end

  task automatic step;
    @(negedge clk);
  endtask

  int stall_run;
  logic [1:0] k;

  initial begin
    reset_n = 1'b0; instr_req = 1'b0; instr_address = '0;
    data_read = 1'b0; data_write = 1'b0; data_address = '0;
    data_writedata = '0; data_byteenable = '0;
    bus_waitrequest = 1'b0; bus_readdata = '0;
    step; step;
    chk("reset bus_read", 32'(bus_read), 32'h0);
    chk("reset bus_address", bus_address, 32'h0);
    chk("reset bus_byteenable", 32'(bus_byteenable), 32'h0);
    chk("reset bus_error", 32'(bus_error), 32'h0);
    chk("reset instr_readdata", instr_readdata, 32'h0);
    reset_n = 1'b1;
    // conflict: both held, grants alternate starting with instruction
    instr_req = 1'b1; instr_address = 32'h100;
    data_read = 1'b1; data_address = 32'h200;
    bus_readdata = 32'hA0;
    for (int i = 1; i <= 8; i++) begin
      step;
      bus_readdata = 32'hA0 + i;
      if (i % 2 == 1) begin
        chk("conflict address", bus_address, (i % 4 == 1) ? 32'h100 : 32'h200);
        chk("conflict bus_read", 32'(bus_read), 32'h1);
      end else begin
        chk("conflict instr_ready", 32'(instr_ready), 32'((i % 4) == 2));
        chk("conflict data_ready", 32'(data_ready), 32'((i % 4) == 0));
      end
      if (i == 2) chk("conflict instr_readdata", instr_readdata, 32'hA1);
      if (i == 4) chk("conflict data_readdata", data_readdata, 32'hA3);
    end
    instr_req = 1'b0; data_read = 1'b0;
    step;
    // single fetch
    instr_req = 1'b1; instr_address = 32'hBFC00004; bus_readdata = 32'h3C081354;
    step;
    chk("fetch bus_address", bus_address, 32'hBFC00004);
    chk("fetch bus_byteenable", 32'(bus_byteenable), 32'hF);
    step;
    chk("fetch instr_ready", 32'(instr_ready), 32'h1);
    chk("fetch instr_readdata", instr_readdata, 32'h3C081354);
    instr_req = 1'b0;
    step;
    // store with three wait cycles
    data_write = 1'b1; data_address = 32'hC; data_writedata = 32'h13540000;
    data_byteenable = 4'hF; bus_waitrequest = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step;
      chk("store bus_write", 32'(bus_write), 32'h1);
      chk("store bus_writedata", bus_writedata, 32'h13540000);
      chk("store data_ready early", 32'(data_ready), 32'h0);
      if (i == 4) bus_waitrequest = 1'b0;
    end
    step;
    chk("store data_ready", 32'(data_ready), 32'h1);
    chk("store data_readdata", data_readdata, 32'hA7);
    data_write = 1'b0;
    step;
    // read and write together: write wins
    data_read = 1'b1; data_write = 1'b1; data_address = 32'h10;
    step;
    chk("rw bus_write", 32'(bus_write), 32'h1);
    chk("rw bus_read", 32'(bus_read), 32'h0);
    step;
    chk("rw data_ready", 32'(data_ready), 32'h1);
    data_read = 1'b0; data_write = 1'b0;
    step;
    // timeout
    instr_req = 1'b1; instr_address = 32'h40; bus_waitrequest = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      step;
      chk("timeout bus_read", 32'(bus_read), 32'h1);
    end
    step;
    chk("timeout instr_ready", 32'(instr_ready), 32'h1);
    chk("timeout instr_readdata", instr_readdata, 32'h0);
    chk("timeout bus_error", 32'(bus_error), 32'h1);
    instr_req = 1'b0;
    step; step;
    chk("sticky bus_error", 32'(bus_error), 32'h1);
    // reset mid-transfer
    instr_req = 1'b1;
    step;
    chk("midreset bus_read before", 32'(bus_read), 32'h1);
    reset_n = 1'b0; instr_req = 1'b0;
    step;
    chk("midreset bus_read", 32'(bus_read), 32'h0);
    chk("midreset instr_ready", 32'(instr_ready), 32'h0);
    chk("midreset bus_error", 32'(bus_error), 32'h0);
    reset_n = 1'b1; bus_waitrequest = 1'b0;
    // randomized traffic
    stall_run = 0;
    for (int c = 0; c < 4000; c++) begin
      step;
      reset_n = $urandom_range(0, 399) != 0;
      if (instr_ready || !instr_req) begin
        instr_req = $urandom_range(0, 2) != 0;
        instr_address = $urandom;
      end
      if (data_ready || !(data_read || data_write)) begin
        k = 2'($urandom_range(0, 3));
        data_read = k[0]; data_write = k[1];
        data_address = $urandom; data_writedata = $urandom;
        data_byteenable = 4'($urandom);
      end
      if (stall_run > 0) begin
        bus_waitrequest = 1'b1;
        stall_run--;
      end else begin
        bus_waitrequest = $urandom_range(0, 3) == 0;
        if ($urandom_range(0, 39) == 0) stall_run = 6;
      end
      bus_readdata = $urandom;
    end
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
